// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter in front of a single-port data memory, with read-modify-write for partial writes.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (r0 first).
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_r0_req,
  input  logic [ADDR_WIDTH-1:0]     i_r0_addr,
  input  logic                      i_r0_wr,
  input  logic [DATA_WIDTH/8-1:0]   i_r0_be,
  input  logic [DATA_WIDTH-1:0]     i_r0_wdata,
  output logic                      o_r0_ack,
  output logic [DATA_WIDTH-1:0]     o_r0_rdata,
  input  logic                      i_r1_req,
  input  logic [ADDR_WIDTH-1:0]     i_r1_addr,
  input  logic                      i_r1_wr,
  input  logic [DATA_WIDTH/8-1:0]   i_r1_be,
  input  logic [DATA_WIDTH-1:0]     i_r1_wdata,
  output logic                      o_r1_ack,
  output logic [DATA_WIDTH-1:0]     o_r1_rdata,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wrData,
  output logic                      o_mem_wrEnable,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdData,
  output logic                      o_busy
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RMW_READ,
    S_RMW_WRITE,
    S_DONE
  } state_t;

  state_t                state;
  logic                  grant;      // 0 = r0, 1 = r1
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_wr;
  logic [BE_W-1:0]       lat_be;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] merged_next;
`ifdef DMEM_ARB_RR_EN
  logic                  last;       // requester served most recently
`endif

  logic                  win;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wr;
  logic [BE_W-1:0]       sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_partial;

  always_comb begin
`ifdef DMEM_ARB_RR_EN
    if (i_r0_req && i_r1_req) win = ~last;
    else                      win = ~i_r0_req;
`else
    win = ~i_r0_req;
`endif
  end

  assign sel_addr    = win ? i_r1_addr  : i_r0_addr;
  assign sel_wr      = win ? i_r1_wr    : i_r0_wr;
  assign sel_be      = win ? i_r1_be    : i_r0_be;
  assign sel_wdata   = win ? i_r1_wdata : i_r0_wdata;
  assign sel_partial = sel_wr && (sel_be != '1) && (sel_be != '0);

  // Enabled bytes come from the requester, the rest from the word just read.
  always_comb begin
    merged_next = i_mem_rdData;
    for (int b = 0; b < BE_W; b++) begin
      if (lat_be[b]) merged_next[8*b +: 8] = lat_wdata[8*b +: 8];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last       <= 1'b1;
`endif
      lat_addr   <= '0;
      lat_wr     <= 1'b0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      merged     <= '0;
      o_r0_ack   <= 1'b0;
      o_r1_ack   <= 1'b0;
      o_r0_rdata <= '0;
      o_r1_rdata <= '0;
    end else begin
      o_r0_ack <= 1'b0;
      o_r1_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_r0_req || i_r1_req) begin
            grant     <= win;
`ifdef DMEM_ARB_RR_EN
            last      <= win;
`endif
            lat_addr  <= sel_addr;
            lat_wr    <= sel_wr;
            lat_be    <= sel_be;
            lat_wdata <= sel_wdata;
            state     <= sel_partial ? S_RMW_READ : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!lat_wr) begin
            if (grant) o_r1_rdata <= i_mem_rdData;
            else       o_r0_rdata <= i_mem_rdData;
          end
          o_r0_ack <= ~grant;
          o_r1_ack <= grant;
          state    <= S_DONE;
        end
        S_RMW_READ: begin
          merged <= merged_next;
          state  <= S_RMW_WRITE;
        end
        S_RMW_WRITE: begin
          o_r0_ack <= ~grant;
          o_r1_ack <= grant;
          state    <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_mem_addr     = '0;
    o_mem_wrData   = '0;
    o_mem_wrEnable = 1'b0;
    unique case (state)
      S_ACCESS: begin
        o_mem_addr     = lat_addr;
        o_mem_wrData   = lat_wdata;
        o_mem_wrEnable = lat_wr && (lat_be == '1);
      end
      S_RMW_READ: begin
        o_mem_addr = lat_addr;
      end
      S_RMW_WRITE: begin
        o_mem_addr     = lat_addr;
        o_mem_wrData   = merged;
        o_mem_wrEnable = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: transaction-level model checked every cycle, plus directed literal checks.
// Honours DMEM_ARB_RR_EN the same way the design does.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req = 0, r1_req = 0;
  logic [9:0]  r0_addr = 0, r1_addr = 0;
  logic        r0_wr = 0, r1_wr = 0;
  logic [3:0]  r0_be = 0, r1_be = 0;
  logic [31:0] r0_wdata = 0, r1_wdata = 0;
  logic        r0_ack, r1_ack;
  logic [31:0] r0_rdata, r1_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, busy;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_r0_req(r0_req), .i_r0_addr(r0_addr), .i_r0_wr(r0_wr), .i_r0_be(r0_be),
    .i_r0_wdata(r0_wdata), .o_r0_ack(r0_ack), .o_r0_rdata(r0_rdata),
    .i_r1_req(r1_req), .i_r1_addr(r1_addr), .i_r1_wr(r1_wr), .i_r1_be(r1_be),
    .i_r1_wdata(r1_wdata), .o_r1_ack(r1_ack), .o_r1_rdata(r1_rdata),
    .o_mem_addr(mem_addr), .o_mem_wrData(mem_wdata), .o_mem_wrEnable(mem_we),
    .i_mem_rdData(mem_rdata), .o_busy(busy)
  );

  function automatic logic [31:0] seed_val(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Single-port memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = seed_val(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: one transaction at a time, issued in an idle cycle, acked L cycles later.
  int          cyc = 0;
  logic        m_valid = 1'b0;
  int          m_s = 0, m_ack = 0, m_wrc = -1000, m_win = 0, m_last = 1;
  logic [9:0]  m_addr = 0;
  logic        m_wr = 0;
  logic [31:0] m_wd = 0, m_rd = 0;
  logic [31:0] exp_rd [2];

  task automatic model_issue();
    int         w;
    logic [9:0] a;
    logic       wr;
    logic [3:0] be;
    logic [31:0] wd;
    logic       partial;
`ifdef DMEM_ARB_RR_EN
    if (r0_req && r1_req) w = 1 - m_last;
    else                  w = r0_req ? 0 : 1;
`else
    w = r0_req ? 0 : 1;
`endif
    m_last = w;
    a  = (w == 1) ? r1_addr  : r0_addr;
    wr = (w == 1) ? r1_wr    : r0_wr;
    be = (w == 1) ? r1_be    : r0_be;
    wd = (w == 1) ? r1_wdata : r0_wdata;
    partial = wr && (be != 4'hF) && (be != 4'h0);
    m_win  = w;
    m_addr = a;
    m_wr   = wr;
    m_s    = cyc;
    m_ack  = cyc + (partial ? 3 : 2);
    m_wrc  = (wr && be == 4'hF) ? cyc + 1 : (partial ? cyc + 2 : -1000);
    m_rd   = ref_mem[a];
    m_wd   = m_rd;
    for (int b = 0; b < 4; b++) if (be[b]) m_wd[8*b +: 8] = wd[8*b +: 8];
    m_valid = 1'b1;
  endtask

  task automatic compare_outputs();
    logic live, mem_phase, is_ack;
    if (!rst_n) begin
      check("reset_outputs", {r0_ack, r1_ack, busy, mem_we, mem_addr, mem_wdata}, 64'h0);
      check("reset_rdata", {r0_rdata, r1_rdata}, 64'h0);
      return;
    end
    live      = m_valid && cyc > m_s && cyc <= m_ack;
    mem_phase = m_valid && cyc > m_s && cyc <  m_ack;
    is_ack    = m_valid && cyc == m_ack;
    if (is_ack && !m_wr) exp_rd[m_win] = m_rd;
    check("ack0", r0_ack, is_ack && m_win == 0);
    check("ack1", r1_ack, is_ack && m_win == 1);
    check("busy", busy, live);
    check("wr_enable", mem_we, m_valid && cyc == m_wrc);
    check("mem_addr", mem_addr, mem_phase ? m_addr : 10'd0);
    if (m_valid && cyc == m_wrc) check("mem_wrdata", mem_wdata, m_wd);
    else if (!mem_phase)         check("mem_wrdata_idle", mem_wdata, 32'h0);
    check("rdata0", r0_rdata, exp_rd[0]);
    check("rdata1", r1_rdata, exp_rd[1]);
    if (is_ack && m_wr) check("mem_word", mem[m_addr], ref_mem[m_addr]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_val(i);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_valid = 1'b0; m_last = 1; exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      end else begin
        if (m_valid && cyc == m_wrc) ref_mem[m_addr] = m_wd;
        if (!(m_valid && cyc <= m_ack) && (r0_req || r1_req)) model_issue();
      end
      cyc++;
      #1;
      compare_outputs();
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int who, input logic rq, input logic [9:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
    if (who == 0) begin r0_req = rq; r0_addr = a; r0_wr = w; r0_be = b; r0_wdata = d; end
    else          begin r1_req = rq; r1_addr = a; r1_wr = w; r1_be = b; r1_wdata = d; end
  endtask

  // Issue from an idle cycle; lat and wen count cycles after the issue cycle (-1 = never).
  task automatic do_req(input int who, input logic [9:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int lat, output int wen);
    @(negedge clk);
    set_req(who, 1'b1, a, w, b, d);
    lat = -1;
    wen = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_we && wen < 0) wen = i;
      if ((who == 0) ? r0_ack : r1_ack) begin lat = i; break; end
    end
    set_req(who, 1'b0, a, w, b, d);
    if (lat < 0) check("req_timeout", 0, 1);
  endtask

  task automatic random_txn(input int who);
    logic [3:0] b;
    case ($urandom_range(0, 3))
      0:       b = 4'hF;
      1:       b = 4'h0;
      default: b = 4'($urandom);
    endcase
    set_req(who, 1'b1, 10'($urandom_range(0, 31)), 1'($urandom), b, $urandom);
  endtask

  int   lat, wen;
  int   order [4];
  int   n_acks;
  logic act [2];
  logic got;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset during an r0 read: outputs forced to zero and the read never acks.
    @(negedge clk);
    set_req(0, 1'b1, 10'd5, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t1_outputs_in_reset", {r0_ack, r1_ack, busy, mem_we, mem_addr, mem_wdata}, 64'h0);
    end
    set_req(0, 1'b0, 10'd5, 1'b0, 4'h0, 32'h0);
    rst_n = 1'b1;
    got = 1'b0;
    repeat (4) begin @(negedge clk); if (r0_ack) got = 1'b1; end
    check("t1_no_ack_after_reset", got, 1'b0);

    // Full write then read back.
    do_req(0, 10'd3, 1'b1, 4'hF, 32'hDEAD_BEEF, lat, wen);
    check("t2_full_write_latency", lat, 2);
    do_req(0, 10'd3, 1'b0, 4'h0, 32'h0, lat, wen);
    check("t2_read_latency", lat, 2);
    check("t2_read_data", r0_rdata, 32'hDEAD_BEEF);
    check("t2_read_no_write", wen, -1);

    // Partial write through read-modify-write.
    do_req(1, 10'd7, 1'b1, 4'hF, 32'h1122_3344, lat, wen);
    do_req(1, 10'd7, 1'b1, 4'b0010, 32'h0000_AB00, lat, wen);
    check("t3_partial_latency", lat, 3);
    check("t3_partial_wen_cycle", wen, 2);
    check("t3_merged_word", mem[7], 32'h1122_AB44);

    // Full-enable write, then a zero-enable write that must not touch memory.
    do_req(0, 10'd9, 1'b1, 4'hF, 32'hCAFE_F00D, lat, wen);
    check("t4_full_latency", lat, 2);
    check("t4_full_word", mem[9], 32'hCAFE_F00D);
    do_req(0, 10'd9, 1'b1, 4'h0, 32'h1234_5678, lat, wen);
    check("t4_be0_latency", lat, 2);
    check("t4_be0_no_wen", wen, -1);
    check("t4_be0_word", mem[9], 32'hCAFE_F00D);

    // Both requesters held high from reset: grant order.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 10'd1, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b1, 10'd2, 1'b0, 4'h0, 32'h0);
    n_acks = 0;
    for (int i = 0; i < 40 && n_acks < 4; i++) begin
      @(negedge clk);
      if (r0_ack) begin order[n_acks] = 0; n_acks++; end
      else if (r1_ack) begin order[n_acks] = 1; n_acks++; end
    end
    set_req(0, 1'b0, 10'd1, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b0, 10'd2, 1'b0, 4'h0, 32'h0);
    check("t5_ack_count", n_acks, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      check("t5_rr_order", order[i], i % 2);
`else
      check("t5_fixed_order", order[i], 0);
`endif
    end

    // r0 drops its request right after grant; r1 is served in the next idle cycle.
    @(negedge clk);
    set_req(0, 1'b1, 10'd6, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    set_req(0, 1'b0, 10'd6, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b1, 10'd8, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    check("t6_dropped_req_acked", r0_ack, 1'b1);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (r1_ack) begin lat = i; break; end
    end
    set_req(1, 1'b0, 10'd8, 1'b0, 4'h0, 32'h0);
    check("t6_r1_follow_latency", lat, 3);

    // Randomized traffic with occasional resets.
    act[0] = 1'b0;
    act[1] = 1'b0;
    for (int cy = 0; cy < 2000; cy++) begin
      @(negedge clk);
      if (cy == 700 || cy == 1403) begin
        rst_n = 1'b0;
        set_req(0, 1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        set_req(1, 1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
        act[0] = 1'b0;
        act[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end
      for (int who = 0; who < 2; who++) begin
        if (act[who] && ((who == 0) ? r0_ack : r1_ack)) begin
          act[who] = 1'b0;
          if (who == 0) r0_req = 1'b0; else r1_req = 1'b0;
          if ($urandom_range(0, 1) == 1) begin random_txn(who); act[who] = 1'b1; end
        end else if (!act[who] && $urandom_range(0, 2) == 0) begin
          random_txn(who);
          act[who] = 1'b1;
        end
      end
    end
    set_req(0, 1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
    set_req(1, 1'b0, 10'd0, 1'b0, 4'h0, 32'h0);
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
